// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute unit: ALU control codes and FSM state encoding.
package alu_exec_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SLL = 4'b0011;
  localparam logic [3:0] CTRL_SRL = 4'b0100;
  localparam logic [3:0] CTRL_JR  = 4'b0101;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] CTRL_LUI = 4'b1001;
  localparam logic [3:0] CTRL_ORI = 4'b1010;
  localparam logic [3:0] CTRL_JAL = 4'b1110;
  localparam logic [3:0] CTRL_SGE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_exec_mul_seq.sv
// Iterative unsigned shift-add multiplier (low DATA_W bits of the product).
// start_i loads the operands; one shift-add step runs per cycle afterwards.
// done_o is asserted during the final step and product_o then carries the
// accumulator value that step produces.
module alu_mul_seq
  import alu_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

  logic              run_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Conditional add of the multiplicand for the current step
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done_o    = run_q && (cnt_q == '0);
  assign product_o = acc_d;

  // Operand load on start, then one step per cycle down to terminal count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= CNT_W'(MUL_ITER - 1);
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute unit: single-cycle ALU operations plus an iterative multiply.
//
// state | meaning
// IDLE  | ready for a new operation
// MUL   | multiply in progress, new requests ignored
// DONE  | result presented with valid_o for one cycle
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o
);

  state_e            state_q;
  logic              valid_q;
  logic              zero_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign accept    = valid_i && (state_q == ST_IDLE);
  assign mul_start = accept && (ctrl_i == CTRL_MUL);

  // Single-cycle ALU result and branch flag from the presented operands
  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      CTRL_AND: alu_res = src1_i & src2_i;
      CTRL_OR:  alu_res = src1_i | src2_i;
      CTRL_ADD: alu_res = src1_i + src2_i;
      CTRL_SUB: alu_res = src1_i - src2_i;
      CTRL_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      CTRL_SLL: alu_res = src2_i << shamt_i;
      CTRL_SRL: alu_res = src2_i >> src1_i[4:0];
      CTRL_LUI: alu_res = DATA_W'(src2_i[15:0]) << 16;
      CTRL_ORI: alu_res = src1_i | DATA_W'(src2_i[15:0]);
      CTRL_JR,
      CTRL_JAL,
      CTRL_SGE: alu_res = src1_i;
      default:  alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
    if (ctrl_i == CTRL_SGE) alu_zero = ~src1_i[DATA_W-1];
  end

  alu_mul_seq #(
    .DATA_W   (DATA_W),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .mcand_i   (src1_i),
    .mplier_i  (src2_i),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Control FSM with registered result, flag and completion pulse
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (ctrl_i == CTRL_MUL) begin
              state_q <= ST_MUL;
            end else begin
              result_q <= alu_res;
              zero_q   <= alu_zero;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q <= mul_prod;
            zero_q   <= (mul_prod == '0);
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign busy_o   = (state_q == ST_MUL);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed scenarios plus randomized operations.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;

  alu_exec #(.DATA_W(32), .MUL_ITER(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model computed directly from the operation definitions
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic z);
    longint unsigned p;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  r = b << sh;
      4'd4:  r = b >> a[4:0];
      4'd9:  r = {b[15:0], 16'h0000};
      4'd10: r = a | {16'h0000, b[15:0]};
      4'd5, 4'd14, 4'd15: r = a;
      4'd8: begin
        p = longint'(a) * longint'(b);
        r = p[31:0];
      end
      default: r = 32'd0;
    endcase
    z = (c == 4'd15) ? ~a[31] : (r == 32'd0);
  endfunction

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_i && valid_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: valid_o with nothing outstanding, result 0x%08h (cycle %0d)", result_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result_o, e.res);
        check("zero", {31'd0, zero_o}, {31'd0, e.z});
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  int acc_cyc;

  // Wait for ready, present one operation, record expectation at the accept edge
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic        z;
    exp_t        e;
    int          n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("ready_timeout", {31'd0, ready_o}, 32'd1);
      return;
    end
    valid_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    acc_cyc = cyc;
    ref_op(c, a, b, sh, r, z);
    e.res = r;
    e.z   = z;
    e.cyc = acc_cyc + ((c == 4'd8) ? 32 : 0);
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, ready_o}, 32'd1);
    check({tag, "_valid"},  {31'd0, valid_o}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy_o},  32'd0);
    check({tag, "_result"}, result_o,         32'd0);
    check({tag, "_zero"},   {31'd0, zero_o},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_ready;
    logic [3:0] c;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ctrl_i  = 4'd0;
    src1_i  = '0;
    src2_i  = '0;
    shamt_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    // Directed single-cycle operations
    issue(4'b0010, 32'd7, 32'd5, 5'd0);
    issue(4'b0110, 32'd9, 32'd9, 5'd0);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    issue(4'b1001, 32'd0, 32'h0000_1234, 5'd0);
    issue(4'b1111, 32'h8000_0000, 32'd0, 5'd0);
    issue(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    issue(4'b0011, 32'd0, 32'h0000_0003, 5'd31);
    drain();

    // Multiply 6*7: busy for exactly 32 cycles with ready low throughout
    issue(4'b1000, 32'd6, 32'd7, 5'd0);
    n = 0;
    saw_ready = 1'b0;
    @(negedge clk);
    while (busy_o && n < 100) begin
      if (ready_o) saw_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", n, 32);
    check("mul_ready_low", {31'd0, saw_ready}, 32'd0);
    drain();

    // Request held high during a multiply: accepted only in the first IDLE cycle
    issue(4'b1000, 32'h0001_0003, 32'h0000_0101, 5'd0);
    begin
      exp_t e;
      e.res = 32'd100 + 32'd23;
      e.z   = 1'b0;
      e.cyc = acc_cyc + 34;
      q.push_back(e);
      valid_i = 1'b1;
      ctrl_i  = 4'b0010;
      src1_i  = 32'd100;
      src2_i  = 32'd23;
      while (cyc < e.cyc) @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
    drain();

    // Reset in the middle of a multiply aborts it without a completion
    issue(4'b1000, 32'd6, 32'd7, 5'd0);
    repeat (10) @(negedge clk);
    #2;
    rst_i = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_i = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_ready", {31'd0, ready_o}, 32'd1);
    issue(4'b0010, 32'd7, 32'd5, 5'd0);
    drain();

    // Randomized operations, including undefined codes and occasional multiplies
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'd8 && ($urandom_range(0, 2) != 0)) c = 4'd2;
      issue(c, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
